layer3_output_buffer: RTL and testbench
=======================================

Name: layer3_output_buffer

Overview:
- Storage and responder block for the layer-3 maxpooling stage.
- Captures the pooled pixels that the maxpooling engine writes (save_enable, output_row, output_col, output_data) into an internal ROWS x COLS array of 128-bit words.
- When the feature map is complete, it signals the next layer via pixel_store_done. It then serves that layer's row/column read requests with one-cycle latency until the consumer reports completion.

Parameters:
- DATA_W, 128, width of one stored pixel: 8 channels x 16 bits.
- ROWS, 13, feature-map rows stored.
- COLS, 13, feature-map columns stored.
- ADDR_W, 16, width of row/column address ports (the codebase word length).

Ports:
- clk  in  1  clock; all logic is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- save_enable  in  1  write strobe from the maxpooling engine.
- output_row  in  ADDR_W  write row address.
- output_col  in  ADDR_W  write column address.
- output_data  in  DATA_W  write data.
- layer3_calculation_done  in  1  producer finished; informational only, see Behaviour.
- pixel_store_done  out  1  map complete, reads permitted; held high as a level.
- read_pixel_signal  in  1  read strobe from the consumer.
- read_row_addr  in  ADDR_W  read row address.
- read_col_addr  in  ADDR_W  read column address.
- read_data  out  DATA_W  registered read data.
- read_valid  out  1  high one cycle after an accepted read.
- consumer_done  in  1  next layer finished; releases the buffer.
- overflow_err  out  1  sticky flag: a write was dropped.
- addr_err  out  1  sticky flag: an out-of-range address was seen.

Behaviour:
- Reset, while rst=1 at a rising edge:
  - state=FILL, write_count=0.
  - pixel_store_done=0, read_valid=0, read_data=0.
  - overflow_err=0, addr_err=0.
  - Array contents are not cleared.
  - A reset mid-fill or mid-read aborts the operation; the next map starts from count 0.
- Addressing: linear address = row*COLS + col. An address is in range iff row<ROWS and col<COLS.
- FSM states: FILL and FULL.
- FILL:
  - save_enable=1 with an in-range address writes the array and increments write_count.
  - save_enable=1 with an out-of-range address is ignored and sets addr_err.
  - When an accepted write brings write_count to ROWS*COLS, go to FULL. pixel_store_done rises the cycle after that write.
  - Rewriting an already-written address still counts; the producer guarantees each address is written exactly once.
  - layer3_calculation_done does not force the transition.
  - If layer3_calculation_done arrives with write_count<ROWS*COLS, set overflow_err and stay in FILL.
- FULL:
  - pixel_store_done=1.
  - Any save_enable is dropped and sets overflow_err.
  - consumer_done=1: go to FILL, clear write_count, deassert pixel_store_done on the next cycle.
  - If save_enable and consumer_done coincide, the write is dropped and overflow_err is set.
- Reads, in any state:
  - read_pixel_signal=1 at edge N gives read_valid=1 and read_data=array[addr] at edge N+1.
  - An out-of-range read returns read_data=0 with read_valid=1 and sets addr_err.
  - read_data holds its last value when read_valid=0.
  - Reads in FILL are serviced but carry no content guarantee.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
- Back-to-back reads are sustained at one per cycle.
- Both error flags clear only on rst.

Decomposition:
- Shared package (def.svh):
  - LAYER3_OUT_ROWS, LAYER3_OUT_COLS, and LAYER3_OUTPUT_LENGTH=128.
  - The WORDLENGTH constant.
  - A buf_state_t enum {FILL, FULL}.
- One sub-module, pixel_ram_1r1w:
  - Synchronous 1-read/1-write array, depth ROWS*COLS, width DATA_W, read-before-write.
  - It does not reset its contents.

Test Plan:
- Reset mid-fill: write 50 pixels, assert rst for 1 cycle, then write the full map -> pixel_store_done first rises exactly 169 accepted writes after reset, not 119.
- Full fill: write row r, col c with data {8{r*13+c}} in raster order -> pixel_store_done=1 the cycle after the 169th write. Reading (12,12) gives read_data={8{16'd168}} with read_valid one cycle later.
- Back-to-back reads: read (0,0), (0,1), (5,7) on consecutive cycles -> read_valid high 3 consecutive cycles with data {8{0}}, {8{1}}, {8{72}}.
- Overflow: in FULL, pulse save_enable at (0,0) with data all ones -> (0,0) still reads {8{0}}; overflow_err=1. Then pulse consumer_done -> pixel_store_done=0 next cycle and the fill restarts from count 0.
- Range check: write (13,0), then read (0,13) -> the write is ignored and write_count is unchanged. The read returns read_data=0 with read_valid=1, and addr_err=1.

Source files
------------

// File: rtl/layer3_output_buffer_pkg.sv
// Shared constants and types for the layer-3 maxpool output buffer.
package layer3_output_buffer_pkg;

  localparam int LAYER3_OUT_ROWS      = 13;
  localparam int LAYER3_OUT_COLS      = 13;
  localparam int LAYER3_OUTPUT_LENGTH = 128;
  localparam int WORDLENGTH           = 16;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } buf_state_t;

endpackage

// File: rtl/layer3_output_buffer_pixel_ram_1r1w.sv
// Synchronous 1-read/1-write pixel store; a same-address read and write return the old word.
module pixel_ram_1r1w
  import layer3_output_buffer_pkg::*;
#(
  parameter int DATA_W = LAYER3_OUTPUT_LENGTH,
  parameter int DEPTH  = LAYER3_OUT_ROWS * LAYER3_OUT_COLS,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata_p1;

  // p0 -> p1: the array read samples the pre-write contents at the same edge
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata_p1 <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/layer3_output_buffer.sv
// Layer-3 maxpool output buffer: fills a ROWS x COLS map, then serves 1-cycle reads until released.
module layer3_output_buffer
  import layer3_output_buffer_pkg::*;
#(
  parameter int DATA_W = LAYER3_OUTPUT_LENGTH,
  parameter int ROWS   = LAYER3_OUT_ROWS,
  parameter int COLS   = LAYER3_OUT_COLS,
  parameter int ADDR_W = WORDLENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [ADDR_W-1:0] output_row,
  input  logic [ADDR_W-1:0] output_col,
  input  logic [DATA_W-1:0] output_data,
  input  logic              layer3_calculation_done,
  output logic              pixel_store_done,
  input  logic              read_pixel_signal,
  input  logic [ADDR_W-1:0] read_row_addr,
  input  logic [ADDR_W-1:0] read_col_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic              consumer_done,
  output logic              overflow_err,
  output logic              addr_err
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col);
    return (32'(row) < 32'(ROWS)) && (32'(col) < 32'(COLS));
  endfunction

  // Only meaningful for in-range coordinates, so truncating to AW bits loses nothing.
  function automatic logic [AW-1:0] lin_addr(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  buf_state_t        r_state;
  logic [CNT_W-1:0]  r_write_count;
  logic              r_store_done;
  logic              r_overflow_err;
  logic              r_addr_err;
  logic              r_rd_vld_p1;
  logic              r_rd_zero_p1;

  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic [CNT_W-1:0]  w_count_next;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_wr_in_range = in_range(output_row, output_col);
  assign w_rd_in_range = in_range(read_row_addr, read_col_addr);
  assign w_wr_accept   = save_enable && (r_state == FILL) && w_wr_in_range;
  assign w_rd_accept   = read_pixel_signal && w_rd_in_range;
  assign w_count_next  = r_write_count + CNT_W'(w_wr_accept);
  assign w_waddr       = lin_addr(output_row, output_col);
  assign w_raddr       = lin_addr(read_row_addr, read_col_addr);

  pixel_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_accept),
    .i_waddr (w_waddr),
    .i_wdata (output_data),
    .i_re    (w_rd_accept),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  // p0 -> p1: control state, error flags and read-response qualifiers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FILL;
      r_write_count  <= '0;
      r_store_done   <= 1'b0;
      r_overflow_err <= 1'b0;
      r_addr_err     <= 1'b0;
      r_rd_vld_p1    <= 1'b0;
      r_rd_zero_p1   <= 1'b1;
    end else begin
      r_rd_vld_p1 <= read_pixel_signal;
      if (read_pixel_signal) begin
        r_rd_zero_p1 <= !w_rd_in_range;
        if (!w_rd_in_range) r_addr_err <= 1'b1;
      end

      case (r_state)
        FILL: begin
          if (save_enable && !w_wr_in_range) r_addr_err <= 1'b1;
          if (layer3_calculation_done && (w_count_next < CNT_W'(DEPTH)))
            r_overflow_err <= 1'b1;
          if (w_wr_accept) begin
            r_write_count <= w_count_next;
            if (w_count_next == CNT_W'(DEPTH)) begin
              r_state      <= FULL;
              r_store_done <= 1'b1;
            end
          end
        end
        FULL: begin
          if (save_enable) r_overflow_err <= 1'b1;
          if (consumer_done) begin
            r_state       <= FILL;
            r_write_count <= '0;
            r_store_done  <= 1'b0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // The RAM output register is never reset; the zero qualifier masks it after reset and on out-of-range reads.
  assign read_data        = r_rd_zero_p1 ? '0 : w_ram_rdata;
  assign read_valid       = r_rd_vld_p1;
  assign pixel_store_done = r_store_done;
  assign overflow_err     = r_overflow_err;
  assign addr_err         = r_addr_err;

endmodule

// File: tb/tb_layer3_output_buffer.sv
// Bench for layer3_output_buffer: table-driven reads with a response scoreboard plus fill/overflow/range sequences.
module tb_layer3_output_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         save_enable;
  logic [15:0]  output_row, output_col;
  logic [127:0] output_data;
  logic         layer3_calculation_done;
  logic         pixel_store_done;
  logic         read_pixel_signal;
  logic [15:0]  read_row_addr, read_col_addr;
  logic [127:0] read_data;
  logic         read_valid;
  logic         consumer_done;
  logic         overflow_err;
  logic         addr_err;

  layer3_output_buffer dut (
    .clk                     (clk),
    .rst                     (rst),
    .save_enable             (save_enable),
    .output_row              (output_row),
    .output_col              (output_col),
    .output_data             (output_data),
    .layer3_calculation_done (layer3_calculation_done),
    .pixel_store_done        (pixel_store_done),
    .read_pixel_signal       (read_pixel_signal),
    .read_row_addr           (read_row_addr),
    .read_col_addr           (read_col_addr),
    .read_data               (read_data),
    .read_valid              (read_valid),
    .consumer_done           (consumer_done),
    .overflow_err            (overflow_err),
    .addr_err                (addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic mon_en = 1'b0;
  logic issued = 1'b0;

  typedef struct {
    int           row;
    int           col;
    logic [127:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tbl[7];

  function automatic logic [127:0] pix(input int v);
    return {8{16'(v)}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit we, input int wr, input int wc, input logic [127:0] wd,
                       input bit re, input int rr, input int rc, input logic [127:0] rexp,
                       input bit cdone, input bit calc);
    @(posedge clk);
    #1;
    save_enable             = we;
    output_row              = 16'(wr);
    output_col              = 16'(wc);
    output_data             = wd;
    read_pixel_signal       = re;
    read_row_addr           = 16'(rr);
    read_col_addr           = 16'(rc);
    consumer_done           = cdone;
    layer3_calculation_done = calc;
    if (re) exp_q.push_back(rexp);
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic wr_px(input int r, input int c, input logic [127:0] d);
    drive(1, r, c, d, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic rd_px(input int r, input int c, input logic [127:0] e);
    drive(0, 0, 0, '0, 1, r, c, e, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    save_enable = 0; read_pixel_signal = 0; consumer_done = 0; layer3_calculation_done = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Read-response monitor: a read strobe seen at an edge must produce a valid response by the next negedge.
  always @(posedge clk) issued <= read_pixel_signal && !rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (issued) begin
        chk("read_valid", {127'd0, read_valid}, 128'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %h with no expected response", read_data);
        end else begin
          chk("read_data", read_data, exp_q.pop_front());
        end
      end else begin
        chk("valid_idle", {127'd0, read_valid}, 128'd0);
      end
    end
  end

  logic early;

  initial begin
    rd_tbl[0] = '{12, 12, pix(168)};
    rd_tbl[1] = '{0, 0, pix(0)};
    rd_tbl[2] = '{0, 1, pix(1)};
    rd_tbl[3] = '{5, 7, pix(72)};
    rd_tbl[4] = '{0, 13, 128'd0};
    rd_tbl[5] = '{13, 0, 128'd0};
    rd_tbl[6] = '{6, 3, pix(81)};

    rst = 1'b1;
    save_enable = 0; output_row = 0; output_col = 0; output_data = '0;
    layer3_calculation_done = 0; read_pixel_signal = 0; read_row_addr = 0;
    read_col_addr = 0; consumer_done = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_psd", {127'd0, pixel_store_done}, 128'd0);
    chk("rst_valid", {127'd0, read_valid}, 128'd0);
    chk("rst_rdata", read_data, 128'd0);
    chk("rst_ovf", {127'd0, overflow_err}, 128'd0);
    chk("rst_aerr", {127'd0, addr_err}, 128'd0);
    mon_en = 1'b1;

    // Early producer-done flags overflow without completing the map
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0, 1);
    idle();
    @(negedge clk);
    chk("calc_early_ovf", {127'd0, overflow_err}, 128'd1);
    chk("calc_early_psd", {127'd0, pixel_store_done}, 128'd0);

    // Partial fill aborted by reset
    for (int i = 0; i < 50; i++) wr_px(i / 13, i % 13, pix(i));
    do_reset();
    @(negedge clk);
    chk("midrst_ovf", {127'd0, overflow_err}, 128'd0);
    chk("midrst_psd", {127'd0, pixel_store_done}, 128'd0);

    // Full raster fill; done must not rise before the 169th write lands
    early = 1'b0;
    for (int i = 0; i < 169; i++) begin
      wr_px(i / 13, i % 13, pix(i));
      @(negedge clk);
      if (pixel_store_done !== 1'b0) early = 1'b1;
    end
    chk("fill_psd_not_early", {127'd0, early}, 128'd0);
    idle();
    @(negedge clk);
    chk("fill_psd", {127'd0, pixel_store_done}, 128'd1);
    chk("fill_aerr", {127'd0, addr_err}, 128'd0);

    // Back-to-back table reads, including out-of-range ones
    for (int i = 0; i < 7; i++) rd_px(rd_tbl[i].row, rd_tbl[i].col, rd_tbl[i].exp);
    idle();
    idle();
    @(negedge clk);
    chk("rdata_hold", read_data, pix(81));
    chk("rd_aerr", {127'd0, addr_err}, 128'd1);
    chk("pre_ovf", {127'd0, overflow_err}, 128'd0);

    // Write while FULL is dropped
    wr_px(0, 0, {128{1'b1}});
    idle();
    @(negedge clk);
    chk("full_wr_ovf", {127'd0, overflow_err}, 128'd1);
    chk("full_wr_psd", {127'd0, pixel_store_done}, 128'd1);
    rd_px(0, 0, pix(0));
    idle();

    // Release by consumer
    drive(0, 0, 0, '0, 0, 0, 0, '0, 1, 0);
    idle();
    @(negedge clk);
    chk("release_psd", {127'd0, pixel_store_done}, 128'd0);

    // Refill: first write coincides with a read of the same address (old data expected),
    // and an out-of-range write must not advance the count.
    early = 1'b0;
    drive(1, 0, 0, pix(500), 1, 0, 0, pix(0), 0, 0);
    @(negedge clk);
    if (pixel_store_done !== 1'b0) early = 1'b1;
    wr_px(13, 0, pix(999));
    @(negedge clk);
    if (pixel_store_done !== 1'b0) early = 1'b1;
    for (int i = 1; i < 169; i++) begin
      wr_px(i / 13, i % 13, pix(i + 500));
      @(negedge clk);
      if (pixel_store_done !== 1'b0) early = 1'b1;
    end
    chk("refill_psd_not_early", {127'd0, early}, 128'd0);
    idle();
    @(negedge clk);
    chk("refill_psd", {127'd0, pixel_store_done}, 128'd1);
    rd_px(0, 0, pix(500));
    rd_px(12, 12, pix(668));
    idle();
    idle();
    @(negedge clk);
    chk("sticky_aerr", {127'd0, addr_err}, 128'd1);
    chk("sticky_ovf", {127'd0, overflow_err}, 128'd1);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
